// File: rtl/pipelined_rca_pkg.sv
// Shared constants for the pipelined ripple-carry adder.
//   DEF_N      : default operand/sum width
//   DEF_CHUNK  : default bits added per pipeline stage
//   num_stages : pipeline depth for a given width/chunk (N must be a multiple of CHUNK)
package pipelined_rca_pkg;
  localparam int DEF_N     = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int num_stages(input int n, input int chunk);
    return n / chunk;
  endfunction

  localparam int DEF_STAGES = num_stages(DEF_N, DEF_CHUNK);
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_rca_chunk.sv
// Combinational W-bit ripple adder built from fullAdder cells.
//   a, b : W-bit addends
//   ci   : carry into bit 0
//   s    : W-bit sum
//   co   : carry out of bit W-1
//   cmsb : carry into bit W-1 (used for signed overflow on the top chunk)
module rca_chunk
  import pipelined_rca_pkg::*;
#(
  parameter int W = DEF_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : bit_g
    fullAdder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[W];
  assign cmsb = c[W-1];
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: N-bit add split into N/CHUNK stages of CHUNK
// bits each, with a single global stall (adv) for valid/ready flow control.
//   clk, rst          : rising-edge clock, async active-high reset
//   first, second, cin: operands and carry in (accepted when in_valid && in_ready)
//   in_valid/in_ready : input handshake; in_ready = adv
//   sum, cout, ovf    : registered result, carry out, signed overflow
//   out_valid/out_ready: output handshake
// Latency is STAGES edges counting the accepting edge; the last stage's
// registers are the output registers.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] first,
  input  logic [N-1:0] second,
  input  logic         cin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int STAGES = num_stages(N, CHUNK);

  // Whole pipeline moves as one; it only stalls when the output is full and unread.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int SW = (k + 1) * CHUNK;      // completed low sum bits after this stage
    localparam int RW = N - (k + 1) * CHUNK;  // operand bits still to be added

    logic [CHUNK-1:0] a_in, b_in, s;
    logic             c_in, co, vld_in;
    logic [SW-1:0]    sum_d, sum_q;
    logic             vld_q, c_q;

    if (k == 0) begin : src
      // Stage 0 works straight off the ports.
      assign a_in   = first[CHUNK-1:0];
      assign b_in   = second[CHUNK-1:0];
      assign c_in   = cin;
      assign vld_in = in_valid;
      assign sum_d  = s;
    end else begin : src
      assign a_in   = stg[k-1].mid.rem_a[CHUNK-1:0];
      assign b_in   = stg[k-1].mid.rem_b[CHUNK-1:0];
      assign c_in   = stg[k-1].c_q;
      assign vld_in = stg[k-1].vld_q;
      // Deskew: new chunk lands on top of the already-finished low chunks.
      assign sum_d  = {s, stg[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : lst
      logic cmsb, ovf_q;

      rca_chunk #(.W(CHUNK)) u_add (
        .a    (a_in),
        .b    (b_in),
        .ci   (c_in),
        .s    (s),
        .co   (co),
        .cmsb (cmsb)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= cmsb ^ co;
      end
    end else begin : mid
      // Skew: upper operand bits ride along, shifted down so the next
      // stage always consumes the low CHUNK bits.
      logic [RW-1:0] ra_d, rb_d, rem_a, rem_b;

      rca_chunk #(.W(CHUNK)) u_add (
        .a    (a_in),
        .b    (b_in),
        .ci   (c_in),
        .s    (s),
        .co   (co),
        .cmsb ()
      );

      if (k == 0) begin : rsrc
        assign ra_d = first[N-1:CHUNK];
        assign rb_d = second[N-1:CHUNK];
      end else begin : rsrc
        assign ra_d = stg[k-1].mid.rem_a[RW+CHUNK-1:CHUNK];
        assign rb_d = stg[k-1].mid.rem_b[RW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_a <= '0;
          rem_b <= '0;
        end else if (adv) begin
          rem_a <= ra_d;
          rem_b <= rb_d;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        c_q   <= co;
        sum_q <= sum_d;
      end
    end
  end

  assign out_valid = stg[STAGES-1].vld_q;
  assign sum       = stg[STAGES-1].sum_q;
  assign cout      = stg[STAGES-1].c_q;
  assign ovf       = stg[STAGES-1].lst.ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca (N=32, CHUNK=8, latency 4 edges).
module tb_pipelined_rca;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] first, second;
  logic        cin, in_valid, in_ready;
  logic [31:0] sum;
  logic        cout, ovf, out_valid, out_ready;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_rca #(.N(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .first     (first),
    .second    (second),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] t;
    res_t r;
    t      = {1'b0, a} + {1'b0, b} + {32'd0, c};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
    return r;
  endfunction

  // One clock cycle: drive, sample just before the edge, update scoreboard,
  // advance to 1 time unit after the edge. Comparisons are left to callers.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic ordy,
                      output logic ir, output logic ov, output logic popped,
                      output logic have, output res_t cur, output res_t exp);
    in_valid  = v;
    first     = a;
    second    = b;
    cin       = c;
    out_ready = ordy;
    #1;
    ir     = in_ready;
    ov     = out_valid;
    cur    = {sum, cout, ovf};
    popped = out_valid && ordy;
    have   = 1'b0;
    exp    = '0;
    if (popped && exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      have = 1'b1;
    end
    if (v && in_ready) exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; first = '0; second = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_tests++;
    if ({sum, cout, ovf} !== 34'd0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", {sum, cout, ovf}); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic ir, ov, popped, have;
    res_t cur, exp, want;
    int   pop_at = -1, vcnt = 0;
    want = {32'h00010000, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, ir, ov, popped, have, cur, exp);
      if (ov) vcnt++;
      if (popped) begin
        if (pop_at < 0) pop_at = i;
        n_tests++;
        if (!have || cur !== exp || cur !== want) begin
          n_fail++; $display("FAIL single_value: got %h exp %h", cur, want);
        end
      end
    end
    n_tests++;
    if (pop_at != 4) begin n_fail++; $display("FAIL single_latency: got %0d exp 4", pop_at); end
    n_tests++;
    if (vcnt != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d exp 1", vcnt); end
  endtask

  task automatic test_ripple_ovf();
    logic [31:0] va[3], vb[3];
    logic        vc[3];
    res_t        kexp[3];
    logic ir, ov, popped, have;
    res_t cur, exp;
    int   k = 0;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000000; vc[0] = 1'b1; kexp[0] = {32'h00000000, 1'b1, 1'b0};
    va[1] = 32'h7FFFFFFF; vb[1] = 32'h00000001; vc[1] = 1'b0; kexp[1] = {32'h80000000, 1'b0, 1'b1};
    va[2] = 32'h80000000; vb[2] = 32'h80000000; vc[2] = 1'b0; kexp[2] = {32'h00000000, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (i < 3) step(1'b1, va[i], vb[i], vc[i], 1'b1, ir, ov, popped, have, cur, exp);
      else       step(1'b0, '0, '0, 1'b0, 1'b1, ir, ov, popped, have, cur, exp);
      if (popped) begin
        n_tests++;
        if (k > 2 || !have || cur !== exp || cur !== kexp[k]) begin
          n_fail++; $display("FAIL ripple_ovf_%0d: got %h exp %h", k, cur, (k > 2) ? exp : kexp[k]);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 3) begin n_fail++; $display("FAIL ripple_ovf_count: got %0d exp 3", k); end
  endtask

  task automatic test_back_to_back();
    logic ir, ov, popped, have;
    res_t cur, exp;
    int   first_pop = -1, last_pop = -1, pops = 0, ir_bad = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, ir, ov, popped, have, cur, exp);
      if (i < 8 && ir !== 1'b1) ir_bad++;
      if (popped) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        pops++;
        n_tests++;
        if (!have || cur !== exp) begin n_fail++; $display("FAIL b2b_value: got %h exp %h", cur, exp); end
      end
    end
    n_tests++;
    if (ir_bad != 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d low cycles exp 0", ir_bad); end
    n_tests++;
    if (pops != 8 || last_pop - first_pop != 7) begin
      n_fail++; $display("FAIL b2b_cadence: got %0d results over %0d cycles exp 8 over 8", pops, last_pop - first_pop + 1);
    end
  endtask

  task automatic test_backpressure();
    logic ir, ov, popped, have;
    res_t cur, exp, head;
    int   pops = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 4)      step(1'b1, $urandom, $urandom, 1'b0, 1'b1, ir, ov, popped, have, cur, exp);
      else if (i < 9) step(1'b1, $urandom, $urandom, 1'b1, 1'b0, ir, ov, popped, have, cur, exp);
      else            step(1'b0, '0, '0, 1'b0, 1'b1, ir, ov, popped, have, cur, exp);
      if (i >= 4 && i < 9) begin
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        n_tests++;
        if (ir !== 1'b0 || ov !== 1'b1 || cur !== head) begin
          n_fail++; $display("FAIL bp_hold_%0d: got ir=%b ov=%b %h exp ir=0 ov=1 %h", i, ir, ov, cur, head);
        end
      end
      if (popped) begin
        pops++;
        n_tests++;
        if (!have || cur !== exp) begin n_fail++; $display("FAIL bp_value: got %h exp %h", cur, exp); end
      end
    end
    n_tests++;
    if (pops != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d results, %0d pending exp 4, 0", pops, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic ir, ov, popped, have;
    res_t cur, exp, want;
    int   pops = 0, pop_at = -1;
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h11111111 * (i + 1), 32'h01010101, 1'b0, 1'b1, ir, ov, popped, have, cur, exp);
    // one result is now on the outputs and three more are in flight
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || {sum, cout, ovf} !== 34'd0) begin
      n_fail++; $display("FAIL midreset_clear: got ov=%b %h exp ov=0 0", out_valid, {sum, cout, ovf});
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    want = {32'h12345678 + 32'h00000102, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 32'h12345678, 32'h00000102, 1'b0, 1'b1, ir, ov, popped, have, cur, exp);
      if (i == 0) begin
        n_tests++;
        if (ir !== 1'b1) begin n_fail++; $display("FAIL midreset_accept: got in_ready=%b exp 1", ir); end
      end
      if (popped) begin
        pops++;
        if (pop_at < 0) pop_at = i;
        n_tests++;
        if (!have || cur !== exp || cur !== want) begin
          n_fail++; $display("FAIL midreset_value: got %h exp %h", cur, want);
        end
      end
    end
    n_tests++;
    if (pops != 1 || pop_at != 4) begin
      n_fail++; $display("FAIL midreset_stale: got %0d results first at %0d exp 1 at 4", pops, pop_at);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ripple_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits added per pipeline stage; N SHALL be an integer multiple of CHUNK, with STAGES = N/CHUNK.
REQ-003 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, meaning the reset (asynchronous, active-high).
REQ-005 SHALL have port first, input, N, meaning operand A.
REQ-006 SHALL have port second, input, N, meaning operand B.
REQ-007 SHALL have port cin, input, 1, meaning the carry into bit 0.
REQ-008 SHALL have port in_valid, input, 1, meaning the operands are valid.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts the operands this cycle.
REQ-010 SHALL have port sum, output, N, meaning the registered result.
REQ-011 SHALL have port cout, output, 1, meaning the carry out of bit N-1.
REQ-012 SHALL have port ovf, output, 1, meaning signed overflow (carry into MSB XOR cout).
REQ-013 SHALL have port out_valid, output, 1, meaning sum, cout and ovf are valid.
REQ-014 SHALL have port out_ready, input, 1, meaning the downstream consumer takes the result.

Function
REQ-015 SHALL split each add into STAGES ripple-carry chunks; stage i adds bits [i*CHUNK +: CHUNK] plus the carry registered by stage i-1.
REQ-016 SHALL carry the unused upper operand chunks forward in skew registers, and SHALL carry the completed lower sum chunks forward in deskew registers, so that each transaction's bits stay aligned.
REQ-017 SHALL compute stage 0 combinationally from the ports and register it on the accepting edge.
REQ-018 SHALL present the result on the output registers after STAGES rising edges, counting the accepting edge as the first; for N=32, CHUNK=8, a result accepted at edge t SHALL be visible with out_valid=1 after edge t+3.
REQ-019 SHALL define a global advance signal adv = !out_valid || out_ready; all stage registers and valid bits SHALL shift only when adv=1.
REQ-020 SHALL drive in_ready = adv combinationally; a transfer occurs when in_valid && in_ready.
REQ-021 SHALL insert a bubble (stage valid=0) when adv=1 and in_valid=0.
REQ-022 SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0; no transaction SHALL be lost or duplicated.
REQ-023 SHALL sustain one transaction per cycle when out_ready is held at 1.
REQ-024 SHALL compute sum and cout modulo 2^N with full carry propagation across chunk boundaries (e.g. 0xFFFFFFFF + 0 + cin=1 gives 0, cout=1).
REQ-025 SHALL, when CHUNK=N (STAGES=1), degenerate to a single registered adder with latency 1.

Reset
REQ-026 SHALL, on rst=1 and regardless of clk, clear all stage valid bits, out_valid, sum, cout, ovf and all carry/skew registers to 0.
REQ-027 SHALL discard any in-flight transactions on reset mid-operation, with no partial result emitted.
REQ-028 SHALL drive in_ready=1 while out_valid=0 after reset, and SHALL accept the first transfer on the first clk edge after rst deasserts.

Structure
REQ-029 SHALL place the default constants (N=32, CHUNK=8) and the STAGES derivation in the shared package/include used by the arithmetic blocks.
REQ-030 SHALL implement one sub-module, rca_chunk: a CHUNK-wide combinational ripple adder built from the existing fullAdder cell, with ports for carry-in, carry-out and carry into the MSB.
REQ-031 SHALL instantiate rca_chunk STAGES times in a generate loop; the pipeline registers stay in pipelined_rca.

Verification
REQ-032 SHALL cover the single add: first=0x0000FFFF, second=0x00000001, cin=0, out_ready=1 -> after 4 edges sum=0x00010000, cout=0, ovf=0, out_valid for exactly one cycle.
REQ-033 SHALL cover the full ripple: 0xFFFFFFFF + 0x00000000 + cin=1 -> sum=0, cout=1, ovf=0.
REQ-034 SHALL cover signed overflow: 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1; also 0x80000000 + 0x80000000 -> sum=0, cout=1, ovf=1.
REQ-035 SHALL cover back-to-back streaming: 8 consecutive transfers with out_ready=1 -> 8 results in order on consecutive cycles, in_ready constantly 1.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles while a result is pending -> outputs held, in_ready=0, no input accepted; after release, all results arrive in order with none missing.
REQ-037 SHALL cover reset mid-flight: assert rst with 3 transactions in flight -> out_valid=0 and sum=0 immediately; no stale result appears after rst deasserts.
